// File: rtl/lc3_ir_fetch.sv
// lc3_ir_fetch
// Instruction-fetch stage of the simplified LC-3 datapath. Holds the PC and
// reads one instruction word at a time from instruction memory. Each word is
// latched into IR and offered to decode. The immediate fields of IR are
// broken out for the sign-extension units. A branch or jump target can be
// loaded into the PC on the cycle decode accepts the instruction.
//
// Flow: IDLE -> REQ (read outstanding) -> HOLD (IR offered) -> REQ or IDLE.
// Every output comes from a register or is a slice of one. No input reaches
// an output in the same cycle.

module lc3_ir_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Run,

  // Instruction memory read port
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,

  // Hand-off to decode
  output logic        ir_valid,
  input  logic        ir_ready,

  // PC redirect from the address adder
  input  logic        redirect,
  input  logic [15:0] redirect_pc,

  // Architectural state and IR field breakout
  output logic [15:0] IR,
  output logic [15:0] PC,
  output logic [10:0] off11,
  output logic [8:0]  off9,
  output logic [5:0]  off6,
  output logic [4:0]  imm5,
  output logic [15:0] fetch_count
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    HOLD = 2'b10
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q,    pc_d;
  logic [15:0] ir_q,    ir_d;
  logic [15:0] count_q, count_d;

  // Decode sees an instruction in HOLD, and it is taken when decode is ready.
  logic accept;
  assign accept = (state_q == HOLD) && ir_ready;

  // Next-state and next-value logic for the fetch sequencer.
  // NOTE: every variable gets a default at the top of the block. This way no
  // path leaves a value unassigned, and no latch is inferred.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    count_d = count_q;

    unique case (state_q)
      IDLE: begin
        if (Run) state_d = REQ;
      end

      REQ: begin
        // Run is not looked at here. An outstanding read always completes,
        // and the decision to go idle is made at accept.
        if (mem_ack) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + 16'd1;   // wraps 16'hFFFF -> 16'h0000
          state_d = HOLD;
        end
      end

      HOLD: begin
        if (accept) begin
          count_d = count_q + 16'd1;
          // The target is loaded as-is. The increment has already been
          // applied for the instruction being handed off.
          if (redirect) pc_d = redirect_pc;
          state_d = Run ? REQ : IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register. Mem_ack outside REQ never reaches these flops because the
  // next-value logic only looks at it in REQ.
  // NOTE: sequential state uses non-blocking assignments only, so all flops
  // update together from values computed before the edge.
  // NOTE: IR and fetch_count are plain registers, not memory, so they are
  // reset to known values along with PC and the state.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= 16'h0000;
      count_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      count_q <= count_d;
    end
  end

  // Outputs are decoded from registered state. mem_addr cannot move while
  // mem_rd is high, because PC only changes on the ack edge that leaves REQ.
  assign mem_rd      = (state_q == REQ);
  assign ir_valid    = (state_q == HOLD);
  assign mem_addr    = pc_q;
  assign PC          = pc_q;
  assign IR          = ir_q;
  assign fetch_count = count_q;

  // Immediate fields for the sign-extension units. These are pure slices of IR.
  assign off11 = ir_q[10:0];
  assign off9  = ir_q[8:0];
  assign off6  = ir_q[5:0];
  assign imm5  = ir_q[4:0];

endmodule

// File: tb/tb_lc3_ir_fetch.sv
// Directed testbench for lc3_ir_fetch (RESET_PC = 16'h3000).
// Inputs change 1 ns after each rising edge. Outputs are sampled at that
// same point, well away from the next edge.

module tb_lc3_ir_fetch;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        Run;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        ir_valid;
  logic        ir_ready;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] IR;
  logic [15:0] PC;
  logic [10:0] off11;
  logic [8:0]  off9;
  logic [5:0]  off6;
  logic [4:0]  imm5;
  logic [15:0] fetch_count;

  int checks   = 0;
  int failures = 0;

  lc3_ir_fetch #(.RESET_PC(16'h3000)) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .Run         (Run),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .ir_valid    (ir_valid),
    .ir_ready    (ir_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .IR          (IR),
    .PC          (PC),
    .off11       (off11),
    .off9        (off9),
    .off6        (off6),
    .imm5        (imm5),
    .fetch_count (fetch_count)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [15:0] observed,
                       input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset_n     = 1'b0;
    Run         = 1'b0;
    mem_rdata   = 16'h0000;
    mem_ack     = 1'b0;
    ir_ready    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;

    // Reset values
    tick();
    check("rst_pc",       PC,          16'h3000);
    check("rst_addr",     mem_addr,    16'h3000);
    check("rst_rd",       {15'd0, mem_rd},   16'd0);
    check("rst_valid",    {15'd0, ir_valid}, 16'd0);
    check("rst_ir",       IR,          16'h0000);
    check("rst_count",    fetch_count, 16'h0000);

    // IDLE holds while Run is low, then Run=1 starts a read the next cycle
    Reset_n = 1'b1;
    tick();
    check("idle_rd",      {15'd0, mem_rd}, 16'd0);
    Run = 1'b1;
    tick();
    check("first_rd",     {15'd0, mem_rd}, 16'd1);
    check("first_addr",   mem_addr,    16'h3000);

    // Zero-wait memory, ir_ready high: 1234, 5678, 9ABC
    ir_ready = 1'b1;
    mem_ack = 1'b1; mem_rdata = 16'h1234;
    tick();
    check("zw1_ir",       IR,          16'h1234);
    check("zw1_pc",       PC,          16'h3001);
    check("zw1_valid",    {15'd0, ir_valid}, 16'd1);
    check("zw1_rd",       {15'd0, mem_rd},   16'd0);
    mem_ack = 1'b0;
    tick();
    check("zw1_count",    fetch_count, 16'd1);
    check("zw2_addr",     mem_addr,    16'h3001);
    mem_ack = 1'b1; mem_rdata = 16'h5678;
    tick();
    check("zw2_ir",       IR,          16'h5678);
    check("zw2_pc",       PC,          16'h3002);
    mem_ack = 1'b0;
    tick();
    check("zw2_count",    fetch_count, 16'd2);
    mem_ack = 1'b1; mem_rdata = 16'h9ABC;
    tick();
    check("zw3_ir",       IR,          16'h9ABC);
    check("zw3_pc",       PC,          16'h3003);
    mem_ack = 1'b0;
    tick();
    check("zw3_count",    fetch_count, 16'd3);
    check("zw4_rd",       {15'd0, mem_rd}, 16'd1);

    // Ack delayed 4 cycles: request and address are held
    ir_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("wait_rd",    {15'd0, mem_rd}, 16'd1);
      check("wait_addr",  mem_addr,    16'h3003);
    end
    mem_ack = 1'b1; mem_rdata = 16'h0BFF;
    tick();
    check("slow_ir",      IR,          16'h0BFF);
    check("slow_pc",      PC,          16'h3004);
    mem_ack = 1'b0;

    // ir_ready delayed 3 cycles, with redirect and a stray ack present
    redirect = 1'b1; redirect_pc = 16'h2FF0;
    for (int i = 0; i < 3; i++) begin
      mem_ack   = (i == 1);
      mem_rdata = 16'hDEAD;
      tick();
      check("hold_valid", {15'd0, ir_valid}, 16'd1);
      check("hold_ir",    IR,          16'h0BFF);
      check("hold_pc",    PC,          16'h3004);
      check("hold_count", fetch_count, 16'd3);
    end
    mem_ack = 1'b0;
    check("off11",        {5'd0, off11}, 16'h03FF);
    check("off9",         {7'd0, off9},  16'h01FF);
    check("off6",         {10'd0, off6}, 16'h003F);
    check("imm5",         {11'd0, imm5}, 16'h001F);

    // Accept with redirect: the next request goes to the target
    ir_ready = 1'b1;
    tick();
    check("redir_addr",   mem_addr,    16'h2FF0);
    check("redir_rd",     {15'd0, mem_rd}, 16'd1);
    check("redir_count",  fetch_count, 16'd4);
    tick();
    check("nodup_count",  fetch_count, 16'd4);
    ir_ready = 1'b0; redirect = 1'b0;
    mem_ack = 1'b1; mem_rdata = 16'h1111;
    tick();
    check("redir_pc1",    PC,          16'h2FF1);
    mem_ack = 1'b0;

    // Accept + redirect with Run=0: go idle with PC at the target
    ir_ready = 1'b1; redirect = 1'b1; redirect_pc = 16'hFFFF; Run = 1'b0;
    tick();
    check("idle_pc",      PC,          16'hFFFF);
    check("idle_rd2",     {15'd0, mem_rd},   16'd0);
    check("idle_valid",   {15'd0, ir_valid}, 16'd0);
    check("idle_count",   fetch_count, 16'd5);

    // Stray ack in IDLE is ignored
    ir_ready = 1'b0; redirect = 1'b0;
    mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    tick();
    check("stray_ir",     IR,          16'h1111);
    check("stray_pc",     PC,          16'hFFFF);
    check("stray_rd",     {15'd0, mem_rd}, 16'd0);
    mem_ack = 1'b0;

    // Fetch from FFFF wraps the PC. Run falls together with the ack.
    Run = 1'b1;
    tick();
    check("wrap_addr",    mem_addr,    16'hFFFF);
    Run = 1'b0; mem_ack = 1'b1; mem_rdata = 16'h2222;
    tick();
    check("wrap_pc",      PC,          16'h0000);
    check("wrap_ir",      IR,          16'h2222);
    check("wrap_valid",   {15'd0, ir_valid}, 16'd1);
    mem_ack = 1'b0; ir_ready = 1'b1;
    tick();
    check("wrap_idle",    {15'd0, mem_rd}, 16'd0);
    check("wrap_count",   fetch_count, 16'd6);

    // Async reset in the middle of REQ, then a late ack
    ir_ready = 1'b0; Run = 1'b1;
    tick();
    check("pre_rst_rd",   {15'd0, mem_rd}, 16'd1);
    #2 Reset_n = 1'b0;
    #1;
    check("arst_pc",      PC,          16'h3000);
    check("arst_rd",      {15'd0, mem_rd}, 16'd0);
    check("arst_ir",      IR,          16'h0000);
    check("arst_count",   fetch_count, 16'h0000);
    tick();
    Reset_n = 1'b1; Run = 1'b0;
    mem_ack = 1'b1; mem_rdata = 16'h5555;
    tick();
    check("late_ack_ir",  IR,          16'h0000);
    check("late_ack_rd",  {15'd0, mem_rd}, 16'd0);
    mem_ack = 1'b0; Run = 1'b1;
    tick();
    check("post_rst_addr", mem_addr,   16'h3000);
    mem_ack = 1'b1; mem_rdata = 16'h7777;
    tick();
    check("post_rst_ir",  IR,          16'h7777);
    check("post_rst_pc",  PC,          16'h3001);
    mem_ack = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lc3_ir_fetch.md
# lc3_ir_fetch

Instruction-fetch stage of the simplified LC-3 datapath. Holds the PC, issues word reads to instruction memory through a request/acknowledge handshake, and latches the returned word into IR. Presents IR to decode with a valid/ready handshake and breaks out the immediate fields that feed the 11-, 9-, 6- and 5-bit sign-extension units. Accepts a PC redirect from the address adder at instruction hand-off.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset
- Clk  in  1  system clock, all state on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Run  in  1  level; high enables fetching, low parks the block in IDLE after the current instruction is handed off
- mem_addr  out  16  instruction address, always equals PC
- mem_rd  out  1  read request, held high until acknowledged
- mem_rdata  in  16  read data, valid in the mem_ack cycle
- mem_ack  in  1  one-cycle read acknowledge
- ir_valid  out  1  IR holds an instruction not yet accepted
- ir_ready  in  1  decode accepts IR this cycle
- redirect  in  1  load redirect_pc, sampled only on the accept cycle
- redirect_pc  in  16  branch/jump target
- IR  out  16  instruction register
- PC  out  16  program counter, the address of the next fetch
- off11  out  11  IR[10:0]
- off9  out  9  IR[8:0]
- off6  out  6  IR[5:0]
- imm5  out  5  IR[4:0]
- fetch_count  out  16  number of instructions accepted by decode

## Operation
- Three states: IDLE, REQ, HOLD.
- IDLE:
  - mem_rd=0, ir_valid=0.
  - Run=1 → REQ on the next edge. Run=0 → stay in IDLE.
- REQ:
  - mem_rd=1, mem_addr=PC.
  - mem_ack=1 → IR←mem_rdata, PC←PC+1 (mod 2^16, so 16'hFFFF wraps to 16'h0000), state → HOLD.
  - mem_ack=0 → stay in REQ with all outputs stable.
  - Run is ignored in REQ. An outstanding read always completes.
- HOLD:
  - ir_valid=1, mem_rd=0.
  - ir_ready=1 (accept) → fetch_count←fetch_count+1 (wraps). If redirect=1, PC←redirect_pc; otherwise PC is unchanged. State → REQ if Run=1, else IDLE.
  - ir_ready=0 → IR, PC and ir_valid are held.
- redirect is ignored outside an accept cycle. redirect_pc is written to PC exactly, with no increment.
- mem_ack outside REQ is ignored: no change to IR, PC or state.
- off11, off9, off6 and imm5 are pure combinational slices of IR. They are stable whenever IR is stable.
- Reset (asynchronous, any state): PC=RESET_PC, IR=16'h0000, fetch_count=0, state=IDLE, mem_rd=0, ir_valid=0, mem_addr=RESET_PC. A read in flight at reset is abandoned, and its late mem_ack is ignored per the rule above.

## Timing
- All outputs are registered or decoded from registered state. There is no combinational path from any input to any output.
- mem_rd rises 1 cycle after Run is sampled high in IDLE.
- IR, PC+1 and ir_valid become visible 1 cycle after the mem_ack edge.
- Accept at edge N with Run=1: mem_rd=1 at N+1, with mem_addr equal to the post-redirect PC.
- Peak throughput is 1 instruction per 2 cycles, with zero-wait memory and ir_ready tied high.
- mem_addr does not change while mem_rd=1.
- Simultaneous Run falling and mem_ack in REQ: the fetch completes into HOLD. The IDLE decision is made at accept.
- Simultaneous accept and redirect with Run=0: PC←redirect_pc, state → IDLE. The next Run fetches from the target.

## Test plan
- Reset with RESET_PC=16'h3000 → PC=16'h3000, mem_rd=0, ir_valid=0, IR=0, fetch_count=0; Run=1 → mem_rd=1 and mem_addr=16'h3000 on the next cycle.
- Zero-wait memory returning 16'h1234, 16'h5678, 16'h9ABC, ir_ready tied high → IR shows each word on alternate cycles, PC steps 3001/3002/3003, fetch_count=3.
- mem_ack delayed 4 cycles and ir_ready delayed 3 cycles → mem_rd and mem_addr held for 4 cycles; IR and ir_valid held for 3 cycles; no duplicate fetch_count increment.
- IR=16'h0BFF, accept with redirect=1 and redirect_pc=16'h2FF0 → next mem_addr=16'h2FF0; off9=9'h1FF, off11=11'h3FF, imm5=5'h1F. Also: redirect asserted while ir_ready=0 → ignored.
- PC=16'hFFFF fetch completes → PC=16'h0000; stray mem_ack pulsed in IDLE and in HOLD → no state change.
- Reset_n pulsed low mid-REQ, then a late mem_ack arrives → all outputs return to reset values immediately, the late ack is ignored, and the next fetch comes from RESET_PC.
